// File: rtl/fifo_if.sv
// FIFO handshake bundle: write request/data, read request/data, status flags.
// master = producer/consumer side, slave = FIFO side.
interface fifo_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  empty;
  logic                  full;

  modport master (
    output wr_en, data_in, rd_en,
    input  data_out, empty, full
  );

  modport slave (
    input  wr_en, data_in, rd_en,
    output data_out, empty, full
  );
endinterface

// File: rtl/fifo.sv
// Single-clock circular FIFO, registered read data, empty/full flags.
// Ports: i_clk, i_rst_n (async active-low), bus (fifo_if.slave).
module fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  fifo_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = DEPTH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_data_out;

  logic w_empty;
  logic w_full;
  logic w_wr_acc;
  logic w_rd_acc;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == FULL_CNT);
  // Acceptance uses pre-edge flags: no fall-through when empty,
  // read still frees a slot when full.
  assign w_wr_acc = bus.wr_en && !w_full;
  assign w_rd_acc = bus.rd_en && !w_empty;

  assign bus.empty    = w_empty;
  assign bus.full     = w_full;
  assign bus.data_out = r_data_out;

  always_ff @(posedge i_clk) begin
    if (w_wr_acc)
      r_mem[r_wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data_out <= '0;
    end else begin
      if (w_wr_acc)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) begin
        r_data_out <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + 1'b1;
      end
      unique case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed and random traffic
// against a queue-based reference model.
module tb_fifo;
  logic clk;
  logic rst_n;

  fifo_if #(.DATA_WIDTH(16)) bus ();

  fifo #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] q[$];
  logic [15:0] m_dout;
  int          n_cmp;
  int          n_fail;
  string       cur;
  logic        m_racc;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s observed=%h expected=%h", cur, tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("empty", {15'd0, bus.empty}, {15'd0, q.size() == 0});
    chk("full", {15'd0, bus.full}, {15'd0, q.size() == 16});
    chk("data_out", bus.data_out, m_dout);
  endtask

  task automatic step(input logic wr, input logic [15:0] din,
                      input logic rd);
    logic wacc;
    @(negedge clk);
    bus.wr_en   = wr;
    bus.data_in = din;
    bus.rd_en   = rd;
    @(posedge clk);
    wacc   = wr && (q.size() < 16);
    m_racc = rd && (q.size() != 0);
    if (m_racc) m_dout = q.pop_front();
    if (wacc) q.push_back(din);
    #1;
    check_all();
  endtask

  task automatic idle();
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  initial begin
    int sent;
    int got;
    int cyc;
    logic [15:0] vals[20];
    n_cmp = 0;
    n_fail = 0;
    m_dout = '0;
    m_racc = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.data_in = '0;
    rst_n = 1'b0;

    cur = "reset";
    #2;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    cur = "midreset";
    step(1, 16'h1111, 0);
    step(1, 16'h2222, 0);
    step(1, 16'h3333, 1);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    #2;
    rst_n = 1'b0;
    q.delete();
    m_dout = '0;
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 16'h0, 1);

    cur = "basic";
    step(1, 16'h1234, 0);
    step(1, 16'hABCD, 0);
    step(1, 16'h0001, 0);
    step(0, 16'h0, 1);
    chk("first", bus.data_out, 16'h1234);
    step(0, 16'h0, 1);
    step(0, 16'h0, 1);
    chk("third", bus.data_out, 16'h0001);

    cur = "fill";
    for (int i = 0; i < 16; i++) step(1, 16'(i), 0);
    step(1, 16'hFFFF, 0);
    for (int i = 0; i < 16; i++) step(0, 16'h0, 1);
    chk("last", bus.data_out, 16'h000F);
    step(0, 16'h0, 1);

    cur = "wrap";
    for (int i = 0; i < 10; i++) step(1, 16'h0050 + 16'(i), 0);
    for (int i = 0; i < 10; i++) step(0, 16'h0, 1);
    for (int i = 0; i < 10; i++) step(1, 16'h0100 + 16'(i), 0);
    for (int i = 0; i < 10; i++) step(0, 16'h0, 1);
    chk("wrapend", bus.data_out, 16'h0109);

    cur = "simul";
    for (int i = 0; i < 5; i++) step(1, 16'h0200 + 16'(i), 0);
    for (int i = 0; i < 4; i++) step(1, 16'h0300 + 16'(i), 1);
    for (int i = 0; i < 5; i++) step(0, 16'h0, 1);
    step(1, 16'h0400, 1);
    step(0, 16'h0, 1);

    cur = "simfull";
    for (int i = 0; i < 16; i++) step(1, 16'(i * 3), 0);
    step(1, 16'hBEEF, 1);
    step(1, 16'hCAFE, 0);
    for (int i = 0; i < 17; i++) step(0, 16'h0, 1);

    cur = "stream";
    for (int i = 0; i < 20; i++) vals[i] = 16'($urandom);
    sent = 0;
    got = 0;
    cyc = 0;
    while (got < 20 && cyc < 1000) begin
      logic wr;
      logic rd;
      wr = (sent < 20) && (q.size() < 16) && ($urandom_range(0, 3) != 0);
      rd = (q.size() != 0) && ($urandom_range(0, 2) != 0);
      step(wr, wr ? vals[sent] : 16'h0, rd);
      if (m_racc) begin
        chk("order", bus.data_out, vals[got]);
        got++;
      end
      if (wr) sent++;
      cyc++;
    end
    chk("count", 16'(got), 16'd20);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
